// File: rtl/index_register_pkg.sv
// Shared definitions for the index-register bus: opcodes, IO encodings,
// sequencer states and small helpers used by the sequencer and bus port.
package index_register_pkg;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_LD  = 3'd1;
    localparam logic [2:0] OP_XCH = 3'd2;
    localparam logic [2:0] OP_INC = 3'd3;
    localparam logic [2:0] OP_ISZ = 3'd4;
    localparam logic [2:0] OP_FIM = 3'd5;
    localparam logic [2:0] OP_SRC = 3'd6;
    localparam logic [2:0] OP_CLR = 3'd7;

    localparam logic [1:0] IR_IO_WRITE = 2'b00;
    localparam logic [1:0] IR_IO_READ  = 2'b01;
    localparam logic [1:0] IR_IO_IDLE  = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        RD1  = 3'd2,
        TURN = 3'd3,
        WR0  = 3'd4,
        WR1  = 3'd5,
        DONE = 3'd6
    } seq_state_t;

    // Register of a pair: bit 0 of the requested index is replaced by the half.
    function automatic logic [3:0] pair_reg(input logic [3:0] idx, input logic odd);
        return {idx[3:1], odd};
    endfunction

endpackage

// File: rtl/index_register_sequencer_if.sv
// Command/response handshake between the instruction decoder (master) and
// the index-register sequencer (slave).
interface index_register_sequencer_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_reg;
    logic [7:0] cmd_imm;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_zero;

    modport master (
        output cmd_valid, cmd_op, cmd_reg, cmd_imm,
        input  cmd_ready, rsp_valid, rsp_data, rsp_zero
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_reg, cmd_imm,
        output cmd_ready, rsp_valid, rsp_data, rsp_zero
    );

endinterface

// File: rtl/index_register_sequencer_bus_port.sv
// Tristate driver and read sample register for the shared 4-bit data bus.
// The bus is driven only in write mode; in read mode the value on the bus is
// captured at every edge so a later state can still use an earlier read.
module index_bus_port
    import index_register_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] io,
    input  logic [3:0] wr_data,
    output logic [3:0] rd_now,
    output logic [3:0] rd_q,
    inout  wire  [3:0] data_bus
);

    assign data_bus = (io == IR_IO_WRITE) ? wr_data : 4'bzzzz;
    assign rd_now   = data_bus;

    // Capture the register-file nibble on each edge that ends a read cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q <= 4'h0;
        end else if (io == IR_IO_READ) begin
            rd_q <= data_bus;
        end
    end

endmodule

// File: rtl/index_register_sequencer.sv
// Index-register sequencer: accepts one decoder command at a time and runs
// it as a short read/turnaround/write sequence on the register file.
//
// state | meaning
// IDLE  | cmd_ready high, bus released, select holds last value
// RD0   | register file drives the bus (LD/SRC even/INC/ISZ/XCH)
// RD1   | register file drives odd half of the pair (SRC)
// TURN  | one idle cycle between register-file drive and sequencer drive
// WR0   | sequencer writes first nibble (FIM even, CLR, INC/ISZ/XCH)
// WR1   | sequencer writes odd half of the pair (FIM)
// DONE  | rsp_valid pulse, result registers updated
module index_register_sequencer
    import index_register_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst_n,
    index_register_sequencer_if.slave         cmd_bus,
    output logic [3:0]                        index_register_select,
    output logic [1:0]                        index_register_IO,
    output logic                              index_register_I_WE,
    inout  wire  [3:0]                        data_bus
);

    seq_state_t state;
    logic [2:0] op_q;
    logic [3:0] reg_q;
    logic [7:0] imm_q;
    logic [3:0] sel_q;
    logic [1:0] io_q;
    logic       we_q;
    logic [3:0] wr_q;
    logic       ready_q;
    logic       rsp_valid_q;
    logic [7:0] rsp_data_q;
    logic       rsp_zero_q;
    logic [3:0] rd_now;
    logic [3:0] rd_q;
    logic       accept;

    // ready is also gated by rst_n so it is low for the whole reset window
    assign cmd_bus.cmd_ready = ready_q & rst_n;
    assign cmd_bus.rsp_valid = rsp_valid_q;
    assign cmd_bus.rsp_data  = rsp_data_q;
    assign cmd_bus.rsp_zero  = rsp_zero_q;

    assign index_register_select = sel_q;
    assign index_register_IO     = io_q;
    assign index_register_I_WE   = we_q;

    assign accept = cmd_bus.cmd_valid & ready_q;

    index_bus_port u_bus_port (
        .clk      (clk),
        .rst_n    (rst_n),
        .io       (io_q),
        .wr_data  (wr_q),
        .rd_now   (rd_now),
        .rd_q     (rd_q),
        .data_bus (data_bus)
    );

    // Sequencer FSM with all register-file and response outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            op_q        <= OP_NOP;
            reg_q       <= 4'h0;
            imm_q       <= 8'h00;
            sel_q       <= 4'h0;
            io_q        <= IR_IO_IDLE;
            we_q        <= 1'b0;
            wr_q        <= 4'h0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_zero_q  <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    ready_q <= 1'b1;
                    io_q    <= IR_IO_IDLE;
                    we_q    <= 1'b0;
                    if (accept) begin
                        ready_q <= 1'b0;
                        op_q    <= cmd_bus.cmd_op;
                        reg_q   <= cmd_bus.cmd_reg;
                        imm_q   <= cmd_bus.cmd_imm;
                        case (cmd_bus.cmd_op)
                            OP_NOP: begin
                                state       <= DONE;
                                rsp_valid_q <= 1'b1;
                                rsp_data_q  <= 8'h00;
                                rsp_zero_q  <= 1'b0;
                            end
                            OP_FIM: begin
                                state <= WR0;
                                io_q  <= IR_IO_WRITE;
                                we_q  <= 1'b1;
                                sel_q <= pair_reg(cmd_bus.cmd_reg, 1'b0);
                                wr_q  <= cmd_bus.cmd_imm[7:4];
                            end
                            OP_CLR: begin
                                state <= WR0;
                                io_q  <= IR_IO_WRITE;
                                we_q  <= 1'b1;
                                sel_q <= cmd_bus.cmd_reg;
                                wr_q  <= 4'h0;
                            end
                            OP_SRC: begin
                                state <= RD0;
                                io_q  <= IR_IO_READ;
                                sel_q <= pair_reg(cmd_bus.cmd_reg, 1'b0);
                            end
                            default: begin
                                state <= RD0;
                                io_q  <= IR_IO_READ;
                                sel_q <= cmd_bus.cmd_reg;
                            end
                        endcase
                    end
                end
                RD0: begin
                    case (op_q)
                        OP_SRC: begin
                            state <= RD1;
                            sel_q <= pair_reg(reg_q, 1'b1);
                        end
                        OP_LD: begin
                            state       <= DONE;
                            io_q        <= IR_IO_IDLE;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= {4'h0, rd_now};
                            rsp_zero_q  <= 1'b0;
                        end
                        default: begin
                            state <= TURN;
                            io_q  <= IR_IO_IDLE;
                        end
                    endcase
                end
                RD1: begin
                    // rd_q still holds the even half captured when RD0 ended
                    state       <= DONE;
                    io_q        <= IR_IO_IDLE;
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= {rd_q, rd_now};
                    rsp_zero_q  <= 1'b0;
                end
                TURN: begin
                    state <= WR0;
                    io_q  <= IR_IO_WRITE;
                    we_q  <= 1'b1;
                    wr_q  <= (op_q == OP_XCH) ? imm_q[3:0] : rd_q + 4'd1;
                end
                WR0: begin
                    if (op_q == OP_FIM) begin
                        state <= WR1;
                        sel_q <= pair_reg(reg_q, 1'b1);
                        wr_q  <= imm_q[3:0];
                    end else begin
                        state       <= DONE;
                        io_q        <= IR_IO_IDLE;
                        we_q        <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_zero_q  <= (op_q == OP_ISZ) && (wr_q == 4'h0);
                        // XCH returns the old value; rd_q is untouched while writing
                        rsp_data_q  <= (op_q == OP_XCH) ? {4'h0, rd_q} : {4'h0, wr_q};
                    end
                end
                WR1: begin
                    state       <= DONE;
                    io_q        <= IR_IO_IDLE;
                    we_q        <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= imm_q;
                    rsp_zero_q  <= 1'b0;
                end
                DONE: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    io_q  <= IR_IO_IDLE;
                    we_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
